cp0_int_ctrl: RTL
=================

Name: cp0_int_ctrl

Overview:
- Parametrised coprocessor-0 and interrupt controller for the 5-stage MIPS pipeline. It takes over the fixed 6-line interrupt logic at the MEM stage.
- Holds SR (reg 12), Cause (reg 13), EPC (reg 14) and PRId (reg 15).
- Per line: level or edge sensing, independent masks.
- Decides interrupt entry at the instruction in MEM, emits a one-cycle flush/redirect pulse, handles ERET return.

Parameters:
N_INT, 6, number of hardware interrupt lines, legal range 1..6
EDGE_MASK, 6'b000000, bit i=1 makes line i edge-sensitive (rising edge latched), 0 = level
HANDLER_PC, 32'h0000_4180, interrupt entry vector
PRID_VAL, 32'h0000_0000, read-only PRId contents

Ports:
clk1  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
hw_int  in  N_INT  interrupt lines, synchronous to clk1
m_valid  in  1  MEM stage holds a real (non-bubble) instruction
pc_m  in  32  PC of the MEM-stage instruction
bd_m  in  1  MEM-stage instruction sits in a branch delay slot
cp0_we  in  1  mtc0 in MEM
cp0_addr  in  5  CP0 register number for mtc0/mfc0
cp0_wdata  in  32  mtc0 data
eret_m  in  1  eret in MEM
cp0_rdata  out  32  mfc0 read data, combinational from cp0_addr
int_req  out  1  flush all stages and redirect fetch to int_pc this cycle
int_pc  out  32  HANDLER_PC constant
epc_out  out  32  current EPC, used as the ERET target
exl_out  out  1  SR.EXL

Behaviour:
Reset values:
- SR=0, Cause=0, EPC=0, edge latches=0, hw_int_q=0.
- Resulting outputs: int_req=0, epc_out=0, exl_out=0, cp0_rdata=0 unless addr=15.

Register layout:
- SR: IM[10+N_INT-1:10], EXL[1], IE[0]. All other bits read 0.
- Cause: BD[31], IP[10+N_INT-1:10], ExcCode[6:2]. All other bits read 0.
- Unimplemented addresses read 0.

Pending logic:
- hw_int_q registers hw_int every cycle.
- Edge line i: latch_i set when hw_int[i] & ~hw_int_q[i].
- IP[i] = level line ? hw_int[i] registered : latch_i.
- IP visible one cycle after the input changes.

Take condition:
- take = |(IP & IM) & IE & ~EXL & m_valid & ~eret_m.
- int_req = take, combinational from registered state plus m_valid/eret_m.
- Latency: hw_int asserted in cycle n -> int_req earliest in cycle n+1.

On take (next edge):
- EXL <= 1.
- EPC <= bd_m ? pc_m-4 : pc_m.
- Cause.BD <= bd_m; ExcCode <= 0.
- The faulting instruction is flushed, so a same-cycle mtc0 is suppressed.

ERET:
- When eret_m & m_valid: EXL <= 0.
- Pipeline redirects to epc_out, which must be stable during the ERET cycle.
- ERET with EXL=0 still clears EXL (no-op). No interrupt is taken in the ERET cycle.

mtc0 (cp0_we & m_valid & ~take):
- SR: writes IM/EXL/IE.
- EPC: writes full word.
- Cause: only edge latches are affected. Writing 0 to IP bit i of an edge line clears latch_i. Writing 1 is ignored. Level bits are ignored.
- PRId: write ignored.

Simultaneous events:
- New edge in the same cycle as a software clear: set wins.
- mtc0 SR setting IE=1: takes effect the next cycle.
- int_req asserted while an edge arrives: the latch still sets.

State machine (2 states, encoded by EXL):
- NORMAL -> HANDLER on take.
- HANDLER -> NORMAL on ERET, or on mtc0 clearing EXL.
- In HANDLER, IP keeps updating but take=0.

Reset mid-handler: returns to NORMAL with all latches cleared.

Decomposition:
- Shared package holds CP0 register numbers (SR=12, CAUSE=13, EPC=14, PRID=15), SR/Cause bit positions, and ExcCode values.
- One sub-module, int_pending_latch: per-line edge/level capture with software clear, instantiated with N_INT and EDGE_MASK.

Test Plan:
- Level line 2, SR=0x0000_1001 (IM2, IE), hw_int[2]=1 at cycle n with m_valid, pc_m=0x3010, bd_m=0 -> int_req=1 at n+1; next cycle EPC=0x3010, exl_out=1, Cause[12]=1.
- Same as above with bd_m=1, pc_m=0x3014 -> EPC=0x3010, Cause[31]=1.
- Edge line 0 (EDGE_MASK=1): 1-cycle pulse with IE=0 -> Cause[10] stays 1. mtc0 Cause=0 -> Cause[10]=0. Pulse again with IE=1 -> int_req.
- In handler (EXL=1) with an enabled line pending: no int_req. eret_m=1 -> epc_out drives the redirect, then exl_out=0 and int_req=1 the following cycle.
- mtc0 SR=0xFFFF_FFFF in the same cycle as take -> SR unchanged except EXL=1. Read SR via cp0_addr=12 -> IM bits written only when no take.
- reset low while EXL=1 and latches set -> all registers 0 immediately (async), int_req=0.

Source files
------------

// File: rtl/cp0_int_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions,
// exception codes and the two-state interrupt FSM encoding.
package cp0_int_ctrl_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int unsigned SR_IE_BIT     = 0;
    localparam int unsigned SR_EXL_BIT    = 1;
    localparam int unsigned SR_IM_LSB     = 10;
    localparam int unsigned CAUSE_EXC_LSB = 2;
    localparam int unsigned CAUSE_IP_LSB  = 10;
    localparam int unsigned CAUSE_BD_BIT  = 31;

    localparam logic [4:0] EXC_INT = 5'd0;

    // HANDLER is exactly SR.EXL = 1
    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } cp0_state_e;

endpackage

// File: rtl/cp0_int_ctrl_int_pending_latch.sv
// Per-line interrupt capture: level lines show the registered input,
// edge lines hold a sticky latch set on a rising edge and cleared by software.
module int_pending_latch
    import cp0_int_ctrl_pkg::*;
#(
    parameter int unsigned N_INT     = 6,
    parameter logic [5:0]  EDGE_MASK = 6'b000000
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic [N_INT-1:0] hw_int,
    input  logic [N_INT-1:0] sw_clr,
    output logic [N_INT-1:0] ip
);

    logic [N_INT-1:0] hw_int_q;
    logic [N_INT-1:0] edge_lat;
    logic [N_INT-1:0] edge_en;

    assign edge_en = EDGE_MASK[N_INT-1:0];

    // Input register and edge latches; a new rising edge beats a same-cycle software clear
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            hw_int_q <= '0;
            edge_lat <= '0;
        end else begin
            hw_int_q <= hw_int;
            edge_lat <= edge_en & ((hw_int & ~hw_int_q) | (edge_lat & ~sw_clr));
        end
    end

    assign ip = (edge_en & edge_lat) | (~edge_en & hw_int_q);

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 register file (SR, Cause, EPC, PRId) and MEM-stage interrupt controller.
module cp0_int_ctrl
    import cp0_int_ctrl_pkg::*;
#(
    parameter int unsigned N_INT      = 6,
    parameter logic [5:0]  EDGE_MASK  = 6'b000000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h0000_0000
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic [N_INT-1:0] hw_int,
    input  logic             m_valid,
    input  logic [31:0]      pc_m,
    input  logic             bd_m,
    input  logic             cp0_we,
    input  logic [4:0]       cp0_addr,
    input  logic [31:0]      cp0_wdata,
    input  logic             eret_m,
    output logic [31:0]      cp0_rdata,
    output logic             int_req,
    output logic [31:0]      int_pc,
    output logic [31:0]      epc_out,
    output logic             exl_out
);

    cp0_state_e       state, state_nxt;
    logic [N_INT-1:0] im;
    logic             ie;
    logic [31:0]      epc;
    logic             cause_bd;
    logic [N_INT-1:0] ip;
    logic [N_INT-1:0] sw_clr;
    logic             take;
    logic             wr_en;
    logic             wr_sr;
    logic             wr_cause;
    logic             wr_epc;

    assign take     = (|(ip & im)) & ie & (state == NORMAL) & m_valid & ~eret_m;
    assign wr_en    = cp0_we & m_valid & ~take;
    assign wr_sr    = wr_en & (cp0_addr == CP0_SR);
    assign wr_cause = wr_en & (cp0_addr == CP0_CAUSE);
    assign wr_epc   = wr_en & (cp0_addr == CP0_EPC);
    assign sw_clr   = wr_cause ? ~cp0_wdata[CAUSE_IP_LSB +: N_INT] : '0;

    int_pending_latch #(
        .N_INT     (N_INT),
        .EDGE_MASK (EDGE_MASK)
    ) u_pending (
        .clk1   (clk1),
        .reset  (reset),
        .hw_int (hw_int),
        .sw_clr (sw_clr),
        .ip     (ip)
    );

    // EXL state register
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) state <= NORMAL;
        else        state <= state_nxt;
    end

    // Next EXL: entry on take, exit on ERET or an mtc0 SR write clearing EXL
    always_comb begin
        state_nxt = state;
        if (take)
            state_nxt = HANDLER;
        else if (eret_m && m_valid)
            state_nxt = NORMAL;
        else if (wr_sr)
            state_nxt = cp0_wdata[SR_EXL_BIT] ? HANDLER : NORMAL;
    end

    // SR masks, EPC and Cause.BD; interrupt entry overrides the flushed mtc0
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            im       <= '0;
            ie       <= 1'b0;
            epc      <= '0;
            cause_bd <= 1'b0;
        end else if (take) begin
            epc      <= bd_m ? (pc_m - 32'd4) : pc_m;
            cause_bd <= bd_m;
        end else begin
            if (wr_sr) begin
                im <= cp0_wdata[SR_IM_LSB +: N_INT];
                ie <= cp0_wdata[SR_IE_BIT];
            end
            if (wr_epc)
                epc <= cp0_wdata;
        end
    end

    // mfc0 read mux
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_SR: begin
                cp0_rdata[SR_IM_LSB +: N_INT] = im;
                cp0_rdata[SR_EXL_BIT]         = (state == HANDLER);
                cp0_rdata[SR_IE_BIT]          = ie;
            end
            CP0_CAUSE: begin
                cp0_rdata[CAUSE_BD_BIT]           = cause_bd;
                cp0_rdata[CAUSE_IP_LSB +: N_INT]  = ip;
                cp0_rdata[CAUSE_EXC_LSB +: 5]     = EXC_INT;
            end
            CP0_EPC:  cp0_rdata = epc;
            CP0_PRID: cp0_rdata = PRID_VAL;
            default:  cp0_rdata = '0;
        endcase
    end

    assign int_req = take;
    assign int_pc  = HANDLER_PC;
    assign epc_out = epc;
    assign exl_out = (state == HANDLER);

endmodule
